// File: rtl/tx_packet_arbiter.sv
// Round-robin arbiter sharing one outbound packet path, with inter-packet gap and send watchdog.
// Build option: define TX_ARB_PRIO0_EN to give requester 0 strict priority over the others.
module tx_packet_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int MESSAGE_LENGTH = 48,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*MESSAGE_LENGTH-1:0] req_data,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic [MESSAGE_LENGTH-1:0]         tx_data,
  output logic                              tx_valid,
  input  logic                              tx_ready,
  output logic [$clog2(NUM_REQ)-1:0]        grant_id,
  output logic                              busy,
  output logic                              tx_timeout
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int GW = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0] ID_LAST  = IW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam state_t POST_SEND = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;

  state_t                    state_r, state_s;
  logic [IW-1:0]             rr_ptr_r, rr_ptr_s;
  logic [GW-1:0]             gap_cnt_r, gap_cnt_s;
  logic [TW-1:0]             to_cnt_r, to_cnt_s;
  logic [MESSAGE_LENGTH-1:0] tx_data_s, sel_data_s;
  logic                      tx_valid_s, tx_timeout_s;
  logic [IW-1:0]             grant_id_s;

  logic [NUM_REQ-1:0]        cand_s;
  logic                      hi_found_s, lo_found_s, found_s;
  logic [IW-1:0]             hi_idx_s, lo_idx_s, winner_s, ptr_next_s;

  // Winner search: lowest candidate at or above rr_ptr, else lowest candidate overall (wrap).
  always_comb begin
    cand_s     = req_valid;
    hi_found_s = 1'b0;
    hi_idx_s   = '0;
    lo_found_s = 1'b0;
    lo_idx_s   = '0;
`ifdef TX_ARB_PRIO0_EN
    cand_s[0]  = 1'b0;
`endif
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      lo_idx_s   = cand_s[i[IW-1:0]] ? i[IW-1:0] : lo_idx_s;
      lo_found_s = lo_found_s | cand_s[i[IW-1:0]];
      hi_idx_s   = (cand_s[i[IW-1:0]] && (i[IW-1:0] >= rr_ptr_r)) ? i[IW-1:0] : hi_idx_s;
      hi_found_s = hi_found_s | (cand_s[i[IW-1:0]] && (i[IW-1:0] >= rr_ptr_r));
    end
`ifdef TX_ARB_PRIO0_EN
    if (req_valid[0]) begin
      found_s    = 1'b1;
      winner_s   = '0;
      ptr_next_s = rr_ptr_r;
    end else begin
      found_s    = lo_found_s;
      winner_s   = hi_found_s ? hi_idx_s : lo_idx_s;
      ptr_next_s = (winner_s == ID_LAST) ? '0 : winner_s + IW'(1);
    end
`else
    found_s    = lo_found_s;
    winner_s   = hi_found_s ? hi_idx_s : lo_idx_s;
    ptr_next_s = (winner_s == ID_LAST) ? '0 : winner_s + IW'(1);
`endif
  end

  // Acceptance strobe and selected message; the strobe is suppressed while reset is high.
  always_comb begin
    req_ready  = '0;
    sel_data_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = (state_r == ST_IDLE) && !reset && found_s && (winner_s == i[IW-1:0]);
      sel_data_s   = (winner_s == i[IW-1:0]) ? req_data[i*MESSAGE_LENGTH +: MESSAGE_LENGTH]
                                             : sel_data_s;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s      = state_r;
    rr_ptr_s     = rr_ptr_r;
    gap_cnt_s    = gap_cnt_r;
    to_cnt_s     = to_cnt_r;
    tx_data_s    = tx_data;
    tx_valid_s   = tx_valid;
    grant_id_s   = grant_id;
    tx_timeout_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (found_s) begin
          tx_data_s  = sel_data_s;
          grant_id_s = winner_s;
          rr_ptr_s   = ptr_next_s;
          tx_valid_s = 1'b1;
          to_cnt_s   = '0;
          state_s    = ST_SEND;
        end else begin
          state_s    = ST_IDLE;
        end
      end
      ST_SEND: begin
        // Acceptance has priority over a watchdog expiry in the same cycle.
        if (tx_ready) begin
          tx_valid_s = 1'b0;
          to_cnt_s   = '0;
          gap_cnt_s  = '0;
          state_s    = POST_SEND;
        end else if (to_cnt_r == TO_LAST) begin
          tx_valid_s   = 1'b0;
          tx_timeout_s = 1'b1;
          to_cnt_s     = '0;
          gap_cnt_s    = '0;
          state_s      = POST_SEND;
        end else begin
          to_cnt_s     = to_cnt_r + TW'(1);
        end
      end
      ST_GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          gap_cnt_s = '0;
          state_s   = ST_IDLE;
        end else begin
          gap_cnt_s = gap_cnt_r + GW'(1);
        end
      end
      default: begin
        tx_valid_s = 1'b0;
        state_s    = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Pointer, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_r   <= '0;
      gap_cnt_r  <= '0;
      to_cnt_r   <= '0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      grant_id   <= '0;
      tx_timeout <= 1'b0;
    end else begin
      rr_ptr_r   <= rr_ptr_s;
      gap_cnt_r  <= gap_cnt_s;
      to_cnt_r   <= to_cnt_s;
      tx_data    <= tx_data_s;
      tx_valid   <= tx_valid_s;
      grant_id   <= grant_id_s;
      tx_timeout <= tx_timeout_s;
    end
  end

  assign busy = (state_r != ST_IDLE);

endmodule

// File: tb/tb_tx_packet_arbiter.sv
// Directed bench for tx_packet_arbiter: transaction-level reference model checked every cycle,
// plus literal expectations for the documented scenarios (honours TX_ARB_PRIO0_EN).
module tb_tx_packet_arbiter;
  localparam int N   = 3;
  localparam int ML  = 48;
  localparam int GAP = 4;
  localparam int TMO = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*ML-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic [ML-1:0]   tx_data;
  logic            tx_valid;
  logic            tx_ready;
  logic [1:0]      grant_id;
  logic            busy;
  logic            tx_timeout;

  tx_packet_arbiter #(.NUM_REQ(N), .MESSAGE_LENGTH(ML), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .grant_id(grant_id),
    .busy(busy), .tx_timeout(tx_timeout)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: packet-level phases with plain counters.
  int            m_phase;  // 0 waiting for requests, 1 offering packet, 2 gap
  int            m_ptr, m_gid, m_wait, m_gap;
  logic          m_valid, m_tmo;
  logic [ML-1:0] m_data;
  bit            armed = 1'b0;
  bit            m_just_reset = 1'b0;

  function automatic int pick(input logic [N-1:0] rv, input int ptr);
`ifdef TX_ARB_PRIO0_EN
    if (rv[0]) return 0;
`endif
    for (int k = 0; k < N; k++) begin
      automatic int i = (ptr + k) % N;
`ifdef TX_ARB_PRIO0_EN
      if (i == 0) continue;
`endif
      if (rv[i]) return i;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int w;
    if (reset) begin
      m_phase = 0; m_ptr = 0; m_gid = 0; m_wait = 0; m_gap = 0;
      m_valid = 1'b0; m_tmo = 1'b0; m_data = '0;
      armed = 1'b1; m_just_reset = 1'b1;
    end else begin
      m_just_reset = 1'b0;
      m_tmo = 1'b0;
      if (m_phase == 0) begin
        w = pick(req_valid, m_ptr);
        if (w >= 0) begin
          m_data = req_data[w*ML +: ML];
          m_gid  = w;
`ifdef TX_ARB_PRIO0_EN
          if (w != 0) m_ptr = (w + 1) % N;
`else
          m_ptr = (w + 1) % N;
`endif
          m_valid = 1'b1; m_wait = 0; m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (!tx_ready) m_wait++;
        if (tx_ready || m_wait == TMO) begin
          m_tmo   = !tx_ready;
          m_valid = 1'b0;
          m_gap   = GAP;
          m_phase = (GAP == 0) ? 0 : 2;
        end
      end else begin
        m_gap--;
        if (m_gap == 0) m_phase = 0;
      end
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] exp_rdy;
    int w2;
    if (armed) begin
      exp_rdy = '0;
      if (!reset && m_phase == 0) begin
        w2 = pick(req_valid, m_ptr);
        if (w2 >= 0) exp_rdy[w2] = 1'b1;
      end
      chk("m_req_ready", req_ready, exp_rdy);
      chk("m_tx_valid", tx_valid, m_valid);
      chk("m_busy", busy, m_phase != 0);
      chk("m_tx_timeout", tx_timeout, m_tmo);
      if (m_valid || m_just_reset) begin
        chk("m_tx_data", tx_data, m_data);
        chk("m_grant_id", grant_id, m_gid);
      end
    end
  end

  // Capture buffers for the scenario checks.
  logic tv_h [64];
  logic to_h [64];
  int   rise_gid [16];
  int   rise_cyc [16];
  int   n_rise;

  task automatic record(input int ncyc);
    logic prev = 1'b0;
    n_rise = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      tv_h[i] = tx_valid;
      to_h[i] = tx_timeout;
      if (tx_valid && !prev && n_rise < 16) begin
        rise_gid[n_rise] = int'(grant_id);
        rise_cyc[n_rise] = i;
        n_rise++;
      end
      prev = tx_valid;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = '0; tx_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench time limit");
  end

  initial begin
    int cnt, r0, run, pulses;
    reset = 1'b1; req_valid = '0; req_data = '0; tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Single request from requester 1.
    req_data[1*ML +: ML] = 48'hA5A5_0000_1234;
    req_valid = 3'b010; tx_ready = 1'b1;
    @(negedge clk);
    chk("t1_req_ready", req_ready, 3'b010);
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    chk("t1_tx_valid", tx_valid, 1'b1);
    chk("t1_tx_data", tx_data, 48'hA5A5_0000_1234);
    chk("t1_grant_id", grant_id, 2'd1);
    chk("t1_req_ready_off", req_ready, 3'b000);
    cnt = 1;
    for (int k = 0; k < 20 && busy; k++) begin
      @(negedge clk);
      if (busy) cnt++;
    end
    chk("t1_busy_cycles", cnt, 5);
    @(posedge clk); #1;

    // All requesters pending, splitter always ready.
    do_reset();
    req_data = {48'h2222_2222_2222, 48'h1111_1111_1111, 48'h0000_0000_0ABC};
    req_valid = 3'b111; tx_ready = 1'b1;
    record(45);
    chk("t2_rise_count_ok", n_rise >= 6, 1'b1);
    for (int k = 0; k < 6; k++) begin
      if (k < n_rise) chk("t2_grant_order", rise_gid[k], k % 3);
      if (k > 0 && k < n_rise) chk("t2_spacing", rise_cyc[k] - rise_cyc[k-1], 6);
    end

    // Watchdog: splitter never ready.
    do_reset();
    req_valid = 3'b011; tx_ready = 1'b0;
    record(45);
    chk("t3_rise_count_ok", n_rise >= 2, 1'b1);
    if (n_rise >= 2) begin
      r0 = rise_cyc[0];
      run = 0;
      for (int j = r0; j < 45 && tv_h[j]; j++) run++;
      chk("t3_valid_run", run, 16);
      chk("t3_pulse_at_expiry", to_h[r0+16], 1'b1);
      pulses = 0;
      for (int j = r0; j <= r0 + 30 && j < 45; j++) pulses += int'(to_h[j]);
      chk("t3_single_pulse", pulses, 1);
      chk("t3_first_grant", rise_gid[0], 0);
      chk("t3_next_grant", rise_gid[1], 1);
      chk("t3_next_start", rise_cyc[1] - r0, 21);
    end

    // tx_ready arrives exactly on the expiry cycle.
    do_reset();
    req_valid = 3'b001; tx_ready = 1'b0;
    @(posedge clk); #1 req_valid = '0;
    repeat (15) begin
      @(posedge clk); #1;
    end
    tx_ready = 1'b1;
    @(negedge clk);
    chk("t4_valid_at_expiry", tx_valid, 1'b1);
    @(posedge clk); #1 tx_ready = 1'b0;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      pulses += int'(tx_timeout);
      if (k == 0) chk("t4_valid_dropped", tx_valid, 1'b0);
    end
    chk("t4_no_timeout", pulses, 0);
    @(posedge clk); #1;

    // Reset while a packet is being offered.
    do_reset();
    req_valid = 3'b100; tx_ready = 1'b0;
    @(posedge clk); #1 req_valid = '0;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    req_valid = 3'b111; tx_ready = 1'b1;
    @(negedge clk);
    chk("t5_tx_valid", tx_valid, 1'b0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_grant_id", grant_id, 2'd0);
    chk("t5_tx_timeout", tx_timeout, 1'b0);
    chk("t5_first_grant", req_ready, 3'b001);
    @(posedge clk); #1;

`ifdef TX_ARB_PRIO0_EN
    // Requester 0 strict priority, others round-robin.
    do_reset();
    req_valid = 3'b111; tx_ready = 1'b1;
    record(30);
    chk("t6_rise_count_ok", n_rise >= 4, 1'b1);
    for (int k = 0; k < 4; k++) if (k < n_rise) chk("t6_prio_grant", rise_gid[k], 0);
    req_valid = '0;
    repeat (8) begin
      @(posedge clk); #1;
    end
    req_valid = 3'b110;
    record(30);
    chk("t6_rr_count_ok", n_rise >= 4, 1'b1);
    for (int k = 0; k < 4; k++) if (k < n_rise) chk("t6_rr_grant", rise_gid[k], (k % 2) + 1);
`endif

    req_valid = '0;
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
